// File: rtl/result_uart_tx.sv
// Purpose : serialises one distance/hit result as an 8N1 UART frame (HEADER + 6 data bytes [+ XOR checksum]).
// Latency : tx drops to the start bit one cycle after flashin is accepted; each byte is 10*CLKS_PER_BIT + 1 cycles.
// Backpres: none; flashin while busy is dropped and latches the sticky overrun flag.
//
// Ports   : clock, reset (sync, active-low) | lowest, highest, hitvector (16b result), flashin (capture strobe)
//           tx (serial line, idle high) | busy (frame in flight) | frame_done (1-cycle pulse) | overrun (sticky)
// Config  : define RESULT_UART_CHECKSUM_EN to append byte 7 = XOR of bytes 1..6 (8-byte frame instead of 7).
module result_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [7:0]  HEADER       = 8'hAA
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] lowest,
   input  logic [15:0] highest,
   input  logic [15:0] hitvector,
   input  logic        flashin,
   output logic        tx,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);

   localparam int unsigned    BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
`ifdef RESULT_UART_CHECKSUM_EN
   localparam logic [2:0]     LAST_BYTE = 3'd7;
`else
   localparam logic [2:0]     LAST_BYTE = 3'd6;
`endif

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

   state_t        state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [2:0]    byte_idx;
   logic [7:0]    shreg;
   logic [15:0]   buf_low;
   logic [15:0]   buf_high;
   logic [15:0]   buf_hit;
   logic [2:0]    nxt_idx;
   logic [7:0]    next_byte;
   logic          baud_last;

   assign baud_last = (baud_cnt == BAUD_LAST);
   assign nxt_idx   = byte_idx + 3'd1;

`ifdef RESULT_UART_CHECKSUM_EN
   logic [7:0] csum;
   assign csum = buf_low[7:0] ^ buf_low[15:8] ^ buf_high[7:0] ^ buf_high[15:8]
               ^ buf_hit[7:0] ^ buf_hit[15:8];
`endif

   // Byte to load when NEXT moves on; byte 0 (header) is loaded at capture.
   always_comb begin
      next_byte = HEADER;
      case (nxt_idx)
         3'd1: next_byte = buf_low[7:0];
         3'd2: next_byte = buf_low[15:8];
         3'd3: next_byte = buf_high[7:0];
         3'd4: next_byte = buf_high[15:8];
         3'd5: next_byte = buf_hit[7:0];
         3'd6: next_byte = buf_hit[15:8];
`ifdef RESULT_UART_CHECKSUM_EN
         3'd7: next_byte = csum;
`endif
         default: next_byte = HEADER;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
         shreg      <= '0;
         buf_low    <= '0;
         buf_high   <= '0;
         buf_hit    <= '0;
      end else begin
         frame_done <= 1'b0;
         if (flashin && state != IDLE) overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (flashin) begin
                  buf_low  <= lowest;
                  buf_high <= highest;
                  buf_hit  <= hitvector;
                  shreg    <= HEADER;
                  byte_idx <= '0;
                  bit_idx  <= '0;
                  baud_cnt <= '0;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (baud_last) begin
                  // tx is registered, so bit 0 is presented as DATA is entered
                  // and the shifter is pre-advanced for the next boundary.
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shreg[0];
                  shreg    <= {1'b0, shreg[7:1]};
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  state    <= NEXT;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            NEXT: begin
               if (byte_idx == LAST_BYTE) begin
                  byte_idx   <= '0;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end else begin
                  byte_idx <= nxt_idx;
                  shreg    <= next_byte;
                  tx       <= 1'b0;
                  state    <= START;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_uart_tx.sv
// Purpose : directed self-checking bench for result_uart_tx at CLKS_PER_BIT=4.
// Latency : n/a (bench).
// Backpres: n/a (bench).
module tb_result_uart_tx;

   localparam int CPB      = 4;
   localparam int BYTE_CYC = 10 * CPB + 1;
`ifdef RESULT_UART_CHECKSUM_EN
   localparam int NB = 8;
`else
   localparam int NB = 7;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] lowest = '0;
   logic [15:0] highest = '0;
   logic [15:0] hitvector = '0;
   logic        flashin = 1'b0;
   logic        tx;
   logic        busy;
   logic        frame_done;
   logic        overrun;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] vlo [3];
   logic [15:0] vhi [3];
   logic [15:0] vhv [3];
   logic [7:0]  vexp [3][8];

   result_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hAA)) dut (
      .clock      (clock),
      .reset      (reset),
      .lowest     (lowest),
      .highest    (highest),
      .hitvector  (hitvector),
      .flashin    (flashin),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode 0: plain frame; mode 1: extra flashin with other data at cycle 'at';
   // mode 2: reset pulse at cycle 'at' (frame aborted).
   task automatic run_frame(input int v, input int mode, input int at,
                            input bit chain, input int chain_v, input bit preloaded);
      int         nc;
      int         wave_err;
      int         busy_cnt;
      int         fd_cnt;
      int         b;
      int         r;
      logic [7:0] cur;
      logic [7:0] rx;
      logic       exp_tx;
      nc       = NB * BYTE_CYC;
      wave_err = 0;
      busy_cnt = 0;
      fd_cnt   = 0;
      rx       = '0;
      if (!preloaded) begin
         lowest    = vlo[v];
         highest   = vhi[v];
         hitvector = vhv[v];
         flashin   = 1'b1;
      end
      for (int i = 0; i <= nc; i++) begin
         @(negedge clock);
         if (mode == 2 && i == at + 1) begin
            check($sformatf("abort_tx_v%0d", v), tx, 1);
            check($sformatf("abort_busy_v%0d", v), busy, 0);
            check($sformatf("abort_overrun_v%0d", v), overrun, 0);
            check($sformatf("abort_wave_v%0d", v), wave_err, 0);
            reset = 1'b1;
            return;
         end
         if (i == 0) begin
            check($sformatf("tx_low_after_flashin_v%0d", v), tx, 0);
            flashin = 1'b0;
         end
         if (frame_done) fd_cnt++;
         if (i < nc) begin
            b   = i / BYTE_CYC;
            r   = i % BYTE_CYC;
            cur = vexp[v][b];
            if (r < CPB)          exp_tx = 1'b0;
            else if (r < 9 * CPB) exp_tx = cur[(r - CPB) / CPB];
            else                  exp_tx = 1'b1;
            if (tx !== exp_tx) wave_err++;
            if (busy) busy_cnt++;
            if (r >= CPB && r < 9 * CPB && ((r - CPB) % CPB) == CPB / 2)
               rx = {tx, rx[7:1]};
            if (r == BYTE_CYC - 1)
               check($sformatf("byte%0d_v%0d", b, v), rx, cur);
         end else begin
            check($sformatf("busy_low_end_v%0d", v), busy, 0);
            check($sformatf("frame_done_at_end_v%0d", v), frame_done, 1);
         end
         if (mode == 1 && i == at) begin
            lowest    = 16'hDEAD;
            highest   = 16'hBEEF;
            hitvector = 16'hCAFE;
            flashin   = 1'b1;
         end
         if (mode == 1 && i == at + 1) begin
            flashin = 1'b0;
            check($sformatf("overrun_set_v%0d", v), overrun, 1);
         end
         if (mode == 2 && i == at) reset = 1'b0;
         if (chain && i == nc) begin
            lowest    = vlo[chain_v];
            highest   = vhi[chain_v];
            hitvector = vhv[chain_v];
            flashin   = 1'b1;
         end
      end
      check($sformatf("tx_wave_v%0d", v), wave_err, 0);
      check($sformatf("busy_cycles_v%0d", v), busy_cnt, nc);
      check($sformatf("frame_done_count_v%0d", v), fd_cnt, 1);
      check($sformatf("overrun_end_v%0d", v), overrun, (mode == 1) ? 1 : 0);
   endtask

   task automatic idle_check(input string tag, input int n, input logic exp_ovr);
      int err;
      err = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || overrun !== exp_ovr) err++;
      end
      check(tag, err, 0);
   endtask

   initial begin
      vlo[0] = 16'h1234; vhi[0] = 16'hABCD; vhv[0] = 16'h00FF;
      vexp[0][0] = 8'hAA; vexp[0][1] = 8'h34; vexp[0][2] = 8'h12; vexp[0][3] = 8'hCD;
      vexp[0][4] = 8'hAB; vexp[0][5] = 8'hFF; vexp[0][6] = 8'h00; vexp[0][7] = 8'hBF;
      vlo[1] = 16'h0001; vhi[1] = 16'hFFFF; vhv[1] = 16'h8000;
      vexp[1][0] = 8'hAA; vexp[1][1] = 8'h01; vexp[1][2] = 8'h00; vexp[1][3] = 8'hFF;
      vexp[1][4] = 8'hFF; vexp[1][5] = 8'h00; vexp[1][6] = 8'h80; vexp[1][7] = 8'h81;
      vlo[2] = 16'h0102; vhi[2] = 16'h0304; vhv[2] = 16'h0506;
      vexp[2][0] = 8'hAA; vexp[2][1] = 8'h02; vexp[2][2] = 8'h01; vexp[2][3] = 8'h04;
      vexp[2][4] = 8'h03; vexp[2][5] = 8'h06; vexp[2][6] = 8'h05; vexp[2][7] = 8'h07;

      // Reset state, with flashin high to show capture is blocked by reset.
      reset   = 1'b0;
      flashin = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overrun", overrun, 0);
      flashin = 1'b0;
      reset   = 1'b1;
      idle_check("idle_after_reset", 5, 1'b0);

      run_frame(0, 0, 0, 1'b0, 0, 1'b0);
      idle_check("idle_after_v0", 5, 1'b0);

      // Back-to-back: next flashin lands in the frame_done cycle.
      run_frame(1, 0, 0, 1'b1, 2, 1'b0);
      run_frame(2, 0, 0, 1'b0, 0, 1'b1);
      idle_check("idle_after_chain", 5, 1'b0);

      run_frame(2, 1, 50, 1'b0, 0, 1'b0);
      idle_check("no_second_frame", 100, 1'b1);

      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("overrun_cleared_by_reset", overrun, 0);
      reset = 1'b1;

      run_frame(0, 2, 100, 1'b0, 0, 1'b0);
      idle_check("idle_after_abort", 60, 1'b0);

      run_frame(1, 0, 0, 1'b0, 0, 1'b0);
      idle_check("idle_final", 5, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
